// File: rtl/wishbone_bus_mux_if.sv
// Bus bundle between the CPU data port, the mux and its NSLV memory-mapped slaves.
// The master modport is the environment (CPU plus slaves); the slave modport is the mux itself.
interface wishbone_bus_mux_if #(
   parameter int NSLV   = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                     cpu_ce_i;
   logic                     cpu_we_i;
   logic [ADDR_W-1:0]        cpu_addr_i;
   logic [DATA_W-1:0]        cpu_data_i;
   logic [DATA_W/8-1:0]      cpu_sel_i;
   logic [DATA_W-1:0]        cpu_data_o;
   logic                     cpu_stall_o;
   logic                     cpu_err_o;
   logic [NSLV-1:0]          slv_ce_o;
   logic                     slv_we_o;
   logic [ADDR_W-1:0]        slv_addr_o;
   logic [DATA_W-1:0]        slv_data_o;
   logic [DATA_W/8-1:0]      slv_sel_o;
   logic [NSLV*DATA_W-1:0]   slv_data_i;
   logic [NSLV-1:0]          slv_ack_i;

   modport master (
      output cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_data_i, cpu_sel_i, slv_data_i, slv_ack_i,
      input  cpu_data_o, cpu_stall_o, cpu_err_o, slv_ce_o, slv_we_o, slv_addr_o, slv_data_o, slv_sel_o
   );

   modport slave (
      input  cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_data_i, cpu_sel_i, slv_data_i, slv_ack_i,
      output cpu_data_o, cpu_stall_o, cpu_err_o, slv_ce_o, slv_we_o, slv_addr_o, slv_data_o, slv_sel_o
   );
endinterface

// File: rtl/wishbone_bus_mux.sv
// Registered CPU-to-slave bus multiplexer with base/mask decode, one transfer at a time.
// Define WB_MUX_TIMEOUT_EN to add an ack timeout that ends a stuck transfer with a bus error.
module wishbone_bus_mux #(
   parameter int                     NSLV     = 4,
   parameter int                     DATA_W   = 32,
   parameter int                     ADDR_W   = 32,
   parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {32'h0000_0000, 32'h1000_0000,
                                                 32'h0200_0000, 32'h0000_0000},
   parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {32'hFF00_0000, 32'hFFFF_F000,
                                                 32'hFFFF_0000, 32'hFFFF_0000},
   parameter int                     TIMEOUT  = 15
) (
   input  logic               clk,
   input  logic               rst,
   wishbone_bus_mux_if.slave  bus
);
   localparam int SEL_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e              state_q;
   logic [NSLV-1:0]     slv_ce_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [SEL_W-1:0]    sel_q;
   logic [DATA_W-1:0]   cpu_data_q;
   logic                err_q;

   logic [NSLV-1:0]     hit_oh;
   logic                hit;
   logic                ack_sel;
   logic [DATA_W-1:0]   rdata_sel;
   logic [DATA_W-1:0]   wdata_d;

`ifdef WB_MUX_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] timer_q;
   logic [7:0] timer_d;
   assign timer_d = timer_q + 8'd1;
`endif

   // Walk from the top index down so the lowest-index hit is the one left standing.
   always_comb begin
      hit    = 1'b0;
      hit_oh = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((bus.cpu_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            hit       = 1'b1;
            hit_oh    = '0;
            hit_oh[i] = 1'b1;
         end
      end
   end

   // The live strobe selects whose ack and data matter; other slaves are ignored.
   always_comb begin
      ack_sel   = 1'b0;
      rdata_sel = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (slv_ce_q[i]) begin
            ack_sel   = bus.slv_ack_i[i];
            rdata_sel = bus.slv_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign wdata_d = bus.cpu_we_i ? bus.cpu_data_i : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         slv_ce_q   <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         sel_q      <= '0;
         cpu_data_q <= '0;
         err_q      <= 1'b0;
`ifdef WB_MUX_TIMEOUT_EN
         timer_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               err_q <= 1'b0;
               if (bus.cpu_ce_i) begin
                  we_q    <= bus.cpu_we_i;
                  addr_q  <= bus.cpu_addr_i;
                  wdata_q <= wdata_d;
                  sel_q   <= bus.cpu_sel_i;
                  if (hit) begin
                     slv_ce_q <= hit_oh;
                     state_q  <= BUSY;
`ifdef WB_MUX_TIMEOUT_EN
                     timer_q  <= '0;
`endif
                  end else begin
                     cpu_data_q <= '0;
                     err_q      <= 1'b1;
                     state_q    <= DONE;
                  end
               end
            end
            BUSY: begin
               if (ack_sel) begin
                  slv_ce_q <= '0;
                  if (!we_q) cpu_data_q <= rdata_sel;
                  state_q  <= DONE;
               end
`ifdef WB_MUX_TIMEOUT_EN
               else if (timer_q == TMO_LAST) begin
                  slv_ce_q   <= '0;
                  cpu_data_q <= '0;
                  err_q      <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  timer_q <= timer_d;
               end
`endif
            end
            DONE: begin
               err_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cpu_stall_o = bus.cpu_ce_i & (state_q != DONE);
   assign bus.cpu_err_o   = err_q;
   assign bus.cpu_data_o  = cpu_data_q;
   assign bus.slv_ce_o    = slv_ce_q;
   assign bus.slv_we_o    = we_q;
   assign bus.slv_addr_o  = addr_q;
   assign bus.slv_data_o  = wdata_q;
   assign bus.slv_sel_o   = sel_q;
endmodule

// File: tb/tb_wishbone_bus_mux.sv
// Self-checking bench for wishbone_bus_mux: directed scenarios plus randomized transfers
// checked against a transaction-level model of the decode map and transfer timing.
module tb_wishbone_bus_mux;
   localparam int NSLV    = 4;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 15;
   localparam logic [NSLV*ADDR_W-1:0] BASE = {32'h0000_0000, 32'h1000_0000, 32'h0200_0000, 32'h0000_0000};
   localparam logic [NSLV*ADDR_W-1:0] MASK = {32'hFF00_0000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_data = 32'h0;

   // Address map as the model sees it: RAM, CLINT, UART, and a wide region overlapping RAM.
   logic [31:0] map_base [NSLV] = '{32'h0000_0000, 32'h0200_0000, 32'h1000_0000, 32'h0000_0000};
   logic [31:0] map_mask [NSLV] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFF00_0000};

   wishbone_bus_mux_if #(.NSLV(NSLV), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wishbone_bus_mux #(
      .NSLV(NSLV), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic int ref_decode(input logic [31:0] addr);
      for (int i = 0; i < NSLV; i++)
         if ((addr & map_mask[i]) == map_base[i]) return i;
      return -1;
   endfunction

   // Runs one transfer starting at a falling edge and ends at the falling edge inside DONE.
   // dly = BUSY cycles without ack before the ack cycle; dly < 0 means the slave never acks.
   task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int dly, input bit from_done,
                           input bit drop_ce, input bit stray, input string nm);
      int          k;
      int          exp_busy;
      logic [31:0] rdata;
      logic [3:0]  exp_oh;
      logic        exp_err;
      k     = ref_decode(addr);
      rdata = $urandom;
      for (int i = 0; i < NSLV; i++)
         bus.slv_data_i[i*32 +: 32] = (i == k) ? rdata : $urandom;
      bus.cpu_ce_i   = 1'b1;
      bus.cpu_we_i   = we;
      bus.cpu_addr_i = addr;
      bus.cpu_data_i = wdata;
      bus.cpu_sel_i  = sel;
      bus.slv_ack_i  = '0;
      if (from_done) begin
         #1;
         checks++;
         if (bus.cpu_stall_o !== 1'b0) begin
            errors++; $display("FAIL %s done_stall: got %b want 0", nm, bus.cpu_stall_o);
         end
         @(posedge clk); @(negedge clk);
         checks++;
         if (bus.slv_ce_o !== 4'b0000) begin
            errors++; $display("FAIL %s early_strobe: got %b want 0000", nm, bus.slv_ce_o);
         end
      end
      #1;
      checks++;
      if (bus.cpu_stall_o !== 1'b1) begin
         errors++; $display("FAIL %s req_stall: got %b want 1", nm, bus.cpu_stall_o);
      end
      @(posedge clk); @(negedge clk);
      if (k < 0) begin
         exp_err  = 1'b1;
         exp_data = 32'h0;
      end else begin
         exp_oh   = 4'b0001 << k;
         exp_busy = (dly < 0) ? TIMEOUT : dly + 1;
         for (int b = 0; b < exp_busy; b++) begin
            if (drop_ce && b == 0) bus.cpu_ce_i = 1'b0;
            checks++;
            if (bus.slv_ce_o !== exp_oh) begin
               errors++; $display("FAIL %s strobe[%0d]: got %b want %b", nm, b, bus.slv_ce_o, exp_oh);
            end
            checks++;
            if ({bus.slv_we_o, bus.slv_addr_o, bus.slv_data_o, bus.slv_sel_o} !==
                {we, addr, (we ? wdata : 32'h0), sel}) begin
               errors++;
               $display("FAIL %s fields[%0d]: got we=%b a=%h d=%h s=%h want we=%b a=%h d=%h s=%h", nm, b,
                        bus.slv_we_o, bus.slv_addr_o, bus.slv_data_o, bus.slv_sel_o,
                        we, addr, (we ? wdata : 32'h0), sel);
            end
            bus.slv_ack_i = (stray && k != 0) ? 4'b0001 : 4'b0000;
            if (b == dly) bus.slv_ack_i[k] = 1'b1;
            #1;
            checks++;
            if (bus.cpu_stall_o !== bus.cpu_ce_i) begin
               errors++; $display("FAIL %s busy_stall[%0d]: got %b want %b", nm, b, bus.cpu_stall_o, bus.cpu_ce_i);
            end
            @(posedge clk); @(negedge clk);
         end
         bus.slv_ack_i = '0;
         exp_err = (dly < 0);
         if (dly < 0) exp_data = 32'h0;
         else if (!we) exp_data = rdata;
      end
      checks++;
      if (bus.slv_ce_o !== 4'b0000) begin
         errors++; $display("FAIL %s done_strobe: got %b want 0000", nm, bus.slv_ce_o);
      end
      checks++;
      if (bus.cpu_stall_o !== 1'b0) begin
         errors++; $display("FAIL %s release: got stall %b want 0", nm, bus.cpu_stall_o);
      end
      checks++;
      if (bus.cpu_err_o !== exp_err) begin
         errors++; $display("FAIL %s err: got %b want %b", nm, bus.cpu_err_o, exp_err);
      end
      checks++;
      if (bus.cpu_data_o !== exp_data) begin
         errors++; $display("FAIL %s rdata: got %h want %h", nm, bus.cpu_data_o, exp_data);
      end
   endtask

   task automatic idle_cycle(input string nm);
      bus.cpu_ce_i = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({bus.cpu_err_o, bus.slv_ce_o, bus.cpu_stall_o} !== 6'b0) begin
         errors++; $display("FAIL %s idle: got err=%b ce=%b stall=%b want 0", nm,
                             bus.cpu_err_o, bus.slv_ce_o, bus.cpu_stall_o);
      end
      checks++;
      if (bus.cpu_data_o !== exp_data) begin
         errors++; $display("FAIL %s hold: got %h want %h", nm, bus.cpu_data_o, exp_data);
      end
   endtask

   task automatic test_reset();
      bus.cpu_ce_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
      bus.cpu_sel_i = '0; bus.slv_data_i = '0; bus.slv_ack_i = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.cpu_data_o, bus.cpu_stall_o, bus.cpu_err_o, bus.slv_ce_o, bus.slv_we_o,
           bus.slv_addr_o, bus.slv_data_o, bus.slv_sel_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: got ce=%b data=%h err=%b addr=%h want all 0",
                             bus.slv_ce_o, bus.cpu_data_o, bus.cpu_err_o, bus.slv_addr_o);
      end
      rst = 1'b0;
      exp_data = 32'h0;
      @(negedge clk);
   endtask

   task automatic test_write_ram();
      run_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 1'b0, 1'b0, "write_ram");
      idle_cycle("write_ram");
   endtask

   task automatic test_read_clint();
      run_xfer(1'b0, 32'h0200_BFF8, 32'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0, "read_clint");
      idle_cycle("read_clint");
   endtask

   task automatic test_decode_miss();
      run_xfer(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0, "miss");
      idle_cycle("miss");
   endtask

   task automatic test_priority();
      run_xfer(1'b0, 32'h0000_0100, 32'h0, 4'h3, 2, 1'b0, 1'b0, 1'b0, "prio_ram");
      idle_cycle("prio_ram");
      run_xfer(1'b1, 32'h00AB_0004, 32'hCAFE_F00D, 4'hC, 1, 1'b0, 1'b0, 1'b0, "prio_wide");
      idle_cycle("prio_wide");
   endtask

   task automatic test_ce_drop();
      run_xfer(1'b0, 32'h1000_0ABC, 32'h0, 4'hF, 2, 1'b0, 1'b1, 1'b0, "ce_drop");
      idle_cycle("ce_drop");
   endtask

`ifdef WB_MUX_TIMEOUT_EN
   task automatic test_timeout();
      run_xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF, -1, 1'b0, 1'b0, 1'b0, "timeout");
      idle_cycle("timeout");
      run_xfer(1'b0, 32'h0000_0044, 32'h0, 4'hF, TIMEOUT - 1, 1'b0, 1'b0, 1'b0, "ack_at_limit");
      idle_cycle("ack_at_limit");
   endtask
`endif

   task automatic test_reset_mid_busy();
      bus.cpu_ce_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0020;
      bus.cpu_sel_i = 4'hF; bus.slv_ack_i = '0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.slv_ce_o !== 4'b0001) begin
         errors++; $display("FAIL rst_busy_strobe: got %b want 0001", bus.slv_ce_o);
      end
      bus.cpu_ce_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.slv_ce_o, bus.cpu_stall_o, bus.cpu_err_o, bus.cpu_data_o} !== '0) begin
         errors++; $display("FAIL rst_async: got ce=%b stall=%b err=%b data=%h want 0",
                             bus.slv_ce_o, bus.cpu_stall_o, bus.cpu_err_o, bus.cpu_data_o);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_data = 32'h0;
      @(negedge clk);
      run_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 1'b0, 1'b0, "post_rst");
      idle_cycle("post_rst");
   endtask

   task automatic test_back_to_back();
      run_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, 1'b0, 1'b0, 1'b0, "b2b_read");
      run_xfer(1'b1, 32'h0200_4000, 32'h1357_9BDF, 4'h5, 3, 1'b1, 1'b0, 1'b1, "b2b_write");
      idle_cycle("b2b");
   endtask

   task automatic test_random();
      logic [31:0] addr;
      bit          in_done;
      int          region;
      in_done = 1'b0;
      for (int n = 0; n < 24; n++) begin
         region = $urandom_range(0, 4);
         case (region)
            0:       addr = {16'h0000, 16'($urandom)};
            1:       addr = {16'h0200, 16'($urandom)};
            2:       addr = {20'h10000, 12'($urandom)};
            3:       addr = {8'h00, 8'($urandom_range(1, 255)), 16'($urandom)};
            default: addr = {4'h4, 28'($urandom)};
         endcase
         run_xfer(1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 4),
                  in_done, 1'b0, 1'($urandom), "random");
         in_done = 1'($urandom);
         if (!in_done) idle_cycle("random");
      end
      if (in_done) idle_cycle("random_end");
   endtask

   initial begin
      test_reset();
      test_write_ram();
      test_read_clint();
      test_decode_miss();
      test_priority();
      test_ce_drop();
`ifdef WB_MUX_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_busy();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
